// File: rtl/ex_muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage: one bit per cycle,
// then a sign-fix cycle that writes HI/LO and pulses done.
module ex_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_count;
    logic               r_is_div;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic               r_b_zero;
    logic [WIDTH-1:0]   r_a_orig;
    logic [WIDTH-1:0]   r_opb;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_div0;

    // Operand capture: magnitudes for the signed ops, raw values for unsigned.
    logic               w_signed;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;

    assign w_signed = ~op[0];
    assign w_sign_a = w_signed & src_a[WIDTH-1];
    assign w_sign_b = w_signed & src_b[WIDTH-1];
    assign w_abs_a  = w_sign_a ? (~src_a + 1'b1) : src_a;
    assign w_abs_b  = w_sign_b ? (~src_b + 1'b1) : src_b;

    // Multiply step: upper half of r_acc is the partial sum, lower half the
    // multiplier being shifted out LSB first.
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_acc;

    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
    assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide step: upper half holds the partial remainder, lower half
    // the dividend shifting out MSB first while quotient bits shift in.
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_div_acc;

    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_div_acc   = w_div_diff[WIDTH]
                       ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                       : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

    // Final sign correction and divide-by-zero override.
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_prod = r_neg_lo ? (~r_acc + 1'b1) : r_acc;
    assign w_quo  = r_neg_lo ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_hi ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1)
                             : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            if (r_b_zero) begin
                w_fix_hi = r_a_orig;
                w_fix_lo = {WIDTH{1'b1}};
            end else begin
                w_fix_hi = w_rem;
                w_fix_lo = w_quo;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_b_zero <= 1'b0;
            r_a_orig <= '0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (flush) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_is_div <= op[1];
                            r_neg_lo <= w_sign_a ^ w_sign_b;
                            r_neg_hi <= w_sign_a;
                            r_b_zero <= (src_b == '0);
                            r_a_orig <= src_a;
                            r_count  <= '0;
                            if (op[1]) begin
                                r_opb <= w_abs_b;
                                r_acc <= {{WIDTH{1'b0}}, w_abs_a};
                            end else begin
                                r_opb <= w_abs_a;
                                r_acc <= {{WIDTH{1'b0}}, w_abs_b};
                            end
                            r_state <= S_BUSY;
                        end
                    end
                    S_BUSY: begin
                        r_acc   <= r_is_div ? w_div_acc : w_mul_acc;
                        r_count <= r_count + 1'b1;
                        if (r_count == LAST) begin
                            r_state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        r_hi    <= w_fix_hi;
                        r_lo    <= w_fix_lo;
                        r_div0  <= r_is_div & r_b_zero;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Stall also covers the issue cycle so ID/EX holds the op until it is latched.
    assign stall = ((r_state == S_IDLE) & start & ~flush) | (r_state != S_IDLE);
    assign busy  = (r_state != S_IDLE);
    assign done  = r_done;
    assign div0  = r_div0;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Scoreboard bench for ex_muldiv_seq: directed ops push expected HI/LO/div0 and
// done cycle; a negedge monitor pops and compares on every done pulse.
module tb_ex_muldiv_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         flush;
    logic         stall;
    logic         busy;
    logic         done;
    logic         div0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    ex_muldiv_seq #(.WIDTH(W)) dut (
        .clock (clk),
        .reset (rst),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .stall (stall),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        name;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         div0;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                chk({e.name, "_div0"}, 64'(div0), 64'(e.div0));
                chk({e.name, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
                $display("done %s: hi=%h lo=%h div0=%0d cycle=%0d", e.name, hi, lo, div0, cyc);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge ending cycle 34.
    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                          input logic ed, input bit chk_stall, input bit hold);
        exp_t e;
        op = o; src_a = a; src_b = b; start = 1'b1;
        e.name = name; e.hi = eh; e.lo = el; e.div0 = ed; e.cyc = cyc + 34;
        sb.push_back(e);
        #1;
        if (chk_stall) chk({name, "_stall_c0"}, 64'(stall), 64'd1);
        @(posedge clk); #1;
        if (hold) begin
            src_a = ~a; src_b = 32'h5; op = ~o;
        end else begin
            start = 1'b0;
        end
        for (int k = 1; k <= 34; k++) begin
            if (hold && k == 34) start = 1'b0;
            if (k == 1) chk({name, "_busy_c1"}, 64'(busy), 64'd1);
            if (chk_stall && (k == 1 || k == 33 || k == 34))
                chk($sformatf("%s_stall_c%0d", name, k), 64'(stall), (k < 34) ? 64'd1 : 64'd0);
            if (k == 34) chk({name, "_busy_c34"}, 64'(busy), 64'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_div0", 64'(div0), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0, 0);
        run_op("mult_m3x7", 2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1, 0);
        run_op("div_m7d2",  2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0, 0);
        run_op("divu_7d2",  2'b11, 32'd7,        32'd2,        32'd1,        32'd3,        1'b0, 0, 1);
        run_op("div_7dm2",  2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 0, 0);
        run_op("mult_min2", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 0, 0);
        run_op("mult_m1m1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 0, 0);
        run_op("multu_x16", 2'b01, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0, 0, 0);

        // Flush mid-BUSY: no done, HI/LO keep the multu_x16 result.
        op = 2'b00; src_a = 32'd5; src_b = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        chk("flush_busy_c10", 64'(busy), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy_c11", 64'(busy), 64'd0);
        chk("flush_stall_c11", 64'(stall), 64'd0);
        repeat (30) begin @(posedge clk); #1; end
        chk("flush_hi_kept", 64'(hi), 64'h1);
        chk("flush_lo_kept", 64'(lo), 64'h23456780);

        // Flush and start together: nothing is latched.
        op = 2'b01; src_a = 32'd9; src_b = 32'd9; start = 1'b1; flush = 1'b1;
        #1;
        chk("flushstart_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flushstart_busy", 64'(busy), 64'd0);
        repeat (36) begin @(posedge clk); #1; end
        chk("flushstart_lo_kept", 64'(lo), 64'h23456780);

        run_op("div_m5d0",  2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 0, 0);
        run_op("divu_d0",   2'b11, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF, 1'b1, 0, 0);

        // Reset mid-BUSY clears every output.
        op = 2'b10; src_a = 32'd100; src_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        chk("rstmid_div0_before", 64'(div0), 64'd1);
        chk("rstmid_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_stall", 64'(stall), 64'd0);
        chk("rstmid_done", 64'(done), 64'd0);
        chk("rstmid_div0", 64'(div0), 64'd0);
        chk("rstmid_hi", 64'(hi), 64'd0);
        chk("rstmid_lo", 64'(lo), 64'd0);
        repeat (38) begin @(posedge clk); #1; end

        run_op("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 0, 0);

        repeat (3) begin @(posedge clk); #1; end
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
